dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// Shares the single-port data memory between two requesters: port A (CPU load/store
// path) and port B (debug/DMA reader-writer). Arbitrates per cycle and drives the
// memory control, address and write-data lines. Returns read data with the memory's
// 1-cycle registered latency. Gives the CPU a grant signal to use as its stall source.
// PARAMETERS
// AW       7    word address width (data memory index)
// DW       32   data width
// CW       16   width of the saturating A-stall counter
// B_BURST  4    max consecutive B grants while A is requesting (1..15)
// PORTS
// clk        in   1   rising-edge clock
// rst_n      in   1   asynchronous, active-low reset
// a_req      in   1   port A access request (level, held until a_gnt)
// a_we       in   1   1 = write, 0 = read
// a_addr     in   AW  port A word address
// a_wdata    in   DW  port A write data
// a_gnt      out  1   port A access accepted this cycle (combinational)
// a_rvalid   out  1   port A read data valid (cycle after read grant)
// a_rdata    out  DW  port A read data
// b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata: same as A, for port B
// mem_rd     out  1   memory read strobe
// mem_wr     out  1   memory write strobe (write at clk edge)
// mem_addr   out  AW  memory address
// mem_wdata  out  DW  memory write data
// mem_rdata  in   DW  memory read data, valid 1 cycle after mem_rd
// a_stall_cnt out CW  count of cycles with a_req & ~a_gnt, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async): prio <= A, b_run <= 0, a_rvalid=b_rvalid <= 0,
//   rd_owner <= none, a_stall_cnt <= 0. Gnt/mem strobes are then 0 (no req) or per rules.
// - Grant (combinational, one winner per cycle):
//   only one req -> that port wins; none -> no grant, mem_rd=mem_wr=0.
//   both req -> winner = prio, except: if prio=B and b_run==B_BURST -> A wins.
// - prio update at clk edge: on A win -> prio<=B; on B win -> prio<=A only if a_req,
//   else stays B (B streams freely when A idle).
// - b_run: +1 on each B win while a_req=1; cleared on any A win or on a cycle with
//   a_req=0. Saturates at B_BURST.
// - Mem drive: mem_addr/mem_wdata muxed from winner; mem_rd = win & ~we;
//   mem_wr = win & we. With no winner, mem_addr/mem_wdata = port A values, strobes 0.
// - Read return: rd_owner registered at grant; next cycle x_rvalid=1 for owner only,
//   x_rdata = mem_rdata for both ports (qualify with rvalid). Back-to-back reads
//   fully pipelined: 1 access/cycle throughput.
// - Writes: no rvalid; data committed at grant edge; read of same addr granted
//   next cycle returns new data.
// - Port drops req before grant: no effect, nothing issued. Req changes while
//   ungranted: the current cycle's values are used.
// - a_stall_cnt: +1 each cycle a_req & ~a_gnt, holds at 2^CW-1.
// - Reset mid-read: pending rvalid discarded (not emitted after reset release).
// TESTING
// 1. Reset: rst_n=0 mid-stream -> all rvalid=0, a_stall_cnt=0, prio=A immediately.
// 2. A read alone, addr 5 (mem[5]=0xDEADBEEF) -> a_gnt same cycle, a_rvalid next,
//    a_rdata=0xDEADBEEF; b_rvalid stays 0.
// 3. Both request continuously from reset -> grants A,B,A,B...; a_stall_cnt +1 every 2 cycles.
// 4. B streams 10 reads, A idle, then A requests -> A granted within B_BURST(4) cycles
//    (at first cycle if prio=A); b_run clears.
// 5. A writes 0x12345678 to addr 3, B reads addr 3 next cycle -> b_rdata=0x12345678.
// 6. A held off >2^CW cycles (CW=4 build) -> a_stall_cnt sticks at 15.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU port A and
// debug/DMA port B share it with alternating priority and a bounded B burst.
module dmem_arbiter #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int CW      = 16,
    parameter int B_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] a_stall_cnt
);

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

    localparam logic [3:0]    B_MAX     = 4'(B_BURST);
    localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

    prio_t         prio_r;
    logic [3:0]    b_run_r;
    logic          a_rvalid_r;
    logic          b_rvalid_r;
    logic [CW-1:0] stall_r;
    logic          a_win_s;
    logic          b_win_s;

    // Per-cycle winner selection; B keeps priority only until its burst budget is spent
    always_comb begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
        if (a_req && b_req) begin
            if (prio_r == PRIO_B && b_run_r != B_MAX) begin
                b_win_s = 1'b1;
            end else begin
                a_win_s = 1'b1;
            end
        end else if (a_req) begin
            a_win_s = 1'b1;
        end else if (b_req) begin
            b_win_s = 1'b1;
        end else begin
            a_win_s = 1'b0;
            b_win_s = 1'b0;
        end
    end

    // Memory address/data mux; idle cycles present port A with strobes low
    always_comb begin
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        if (b_win_s) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end else begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end
    end

    assign mem_rd = (a_win_s & ~a_we) | (b_win_s & ~b_we);
    assign mem_wr = (a_win_s & a_we) | (b_win_s & b_we);

    // Priority rotates after each contested grant; B keeps it while A is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= PRIO_A;
        end else if (a_win_s) begin
            prio_r <= PRIO_B;
        end else if (b_win_s) begin
            prio_r <= a_req ? PRIO_A : PRIO_B;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Count consecutive B grants taken while A waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_run_r <= 4'd0;
        end else if (!a_req || a_win_s) begin
            b_run_r <= 4'd0;
        end else if (b_win_s && b_run_r != B_MAX) begin
            b_run_r <= b_run_r + 4'd1;
        end else begin
            b_run_r <= b_run_r;
        end
    end

    // Read owner tracking: memory data comes back one cycle after the read grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rvalid_r <= a_win_s & ~a_we;
            b_rvalid_r <= b_win_s & ~b_we;
        end
    end

    // Saturating count of cycles the CPU spent waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= {CW{1'b0}};
        end else if (a_req && !a_win_s && stall_r != STALL_MAX) begin
            stall_r <= stall_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            stall_r <= stall_r;
        end
    end

    assign a_gnt       = a_win_s;
    assign b_gnt       = b_win_s;
    assign a_rvalid    = a_rvalid_r;
    assign b_rvalid    = b_rvalid_r;
    assign a_rdata     = mem_rdata;
    assign b_rdata     = mem_rdata;
    assign a_stall_cnt = stall_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read data into
// per-port queues, a negedge monitor pops and compares on every rvalid.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] a_stall_cnt;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc;
    int   tests;
    int   fails;

    dmem_arbiter #(.AW(AW), .DW(DW), .CW(CW), .B_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .a_stall_cnt(a_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle registered read
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read-return monitor, one cycle latency enforced through the issue stamp
    always @(negedge clk) begin
        if (rst_n) begin
            if (qa.size() > 0 && qa[0].c < cyc - 1) begin
                tests++; fails++;
                $display("FAIL a_rvalid_missing: got 0 expected 1 (issued cycle %0d)", qa[0].c);
                void'(qa.pop_front());
            end
            if (qb.size() > 0 && qb[0].c < cyc - 1) begin
                tests++; fails++;
                $display("FAIL b_rvalid_missing: got 0 expected 1 (issued cycle %0d)", qb[0].c);
                void'(qb.pop_front());
            end
            if (a_rvalid) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_rvalid_unexpected: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_rvalid_latency", 64'(cyc), 64'(e.c + 1));
                    chk("a_rdata", 64'(a_rdata), 64'(e.d));
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_rvalid_unexpected: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_rvalid_latency", 64'(cyc), 64'(e.c + 1));
                    chk("b_rdata", 64'(b_rdata), 64'(e.d));
                end
            end
        end
    end

    task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic step(input logic ea, input logic eb, input logic [DW-1:0] da,
                        input logic [DW-1:0] db, input string nm);
        @(negedge clk);
        chk({nm, ".a_gnt"}, 64'(a_gnt), 64'(ea));
        chk({nm, ".b_gnt"}, 64'(b_gnt), 64'(eb));
        if (ea && !a_we) qa.push_back('{d: da, c: cyc});
        if (eb && !b_we) qb.push_back('{d: db, c: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        mem_rdata = 32'd0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[5] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);

        // Reset state
        @(negedge clk);
        chk("rst.a_rvalid", 64'(a_rvalid), 64'd0);
        chk("rst.b_rvalid", 64'(b_rvalid), 64'd0);
        chk("rst.stall", 64'(a_stall_cnt), 64'd0);
        chk("rst.mem_rd", 64'(mem_rd), 64'd0);
        chk("rst.mem_wr", 64'(mem_wr), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A read alone from addr 5
        drive(1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        #1;
        chk("rd5.mem_rd", 64'(mem_rd), 64'd1);
        chk("rd5.mem_addr", 64'(mem_addr), 64'd5);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, "rd5");
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, "idle0");

        // Both request continuously from reset: alternate A,B with stall every 2 cycles
        pulse_reset();
        drive(1'b1, 1'b0, 7'd10, 32'd0, 1'b1, 1'b0, 7'd11, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("alt.stall", 64'(a_stall_cnt), 64'(i / 2));
            step(i % 2 == 0, i % 2 == 1, 32'hA000_000A, 32'hA000_000B, "alt");
        end

        // B streams ten reads while A is idle
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'(20 + i), 32'd0);
            step(1'b0, 1'b1, 32'd0, 32'hA000_0000 | 32'(20 + i), "bstream");
        end
        // A arrives while prio is B: one more B grant, then A
        drive(1'b1, 1'b0, 7'd30, 32'd0, 1'b1, 1'b0, 7'd31, 32'd0);
        step(1'b0, 1'b1, 32'd0, 32'hA000_001F, "a_arrive0");
        step(1'b1, 1'b0, 32'hA000_001E, 32'd0, "a_arrive1");
        chk("a_arrive.stall", 64'(a_stall_cnt), 64'd5);
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd31, 32'd0);
        step(1'b0, 1'b1, 32'd0, 32'hA000_001F, "b_after");

        // A write then B read of the same word
        drive(1'b1, 1'b1, 7'd3, 32'h1234_5678, 1'b0, 1'b0, 7'd0, 32'd0);
        #1;
        chk("wr3.mem_wr", 64'(mem_wr), 64'd1);
        chk("wr3.mem_rd", 64'(mem_rd), 64'd0);
        chk("wr3.mem_wdata", 64'(mem_wdata), 64'h1234_5678);
        step(1'b1, 1'b0, 32'd0, 32'd0, "wr3");
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd3, 32'd0);
        #1;
        chk("rd3.mem_addr", 64'(mem_addr), 64'd3);
        step(1'b0, 1'b1, 32'd0, 32'h1234_5678, "rd3");

        // Reset mid-read: pending rvalid dropped, prio back to A immediately
        drive(1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, "pre_rst");
        @(negedge clk);
        chk("mid_rst.a_gnt", 64'(a_gnt), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.a_rvalid", 64'(a_rvalid), 64'd0);
        chk("mid_rst.stall", 64'(a_stall_cnt), 64'd0);
        drive(1'b1, 1'b0, 7'd5, 32'd0, 1'b1, 1'b0, 7'd6, 32'd0);
        #1;
        chk("mid_rst.prio_a", 64'(a_gnt), 64'd1);
        chk("mid_rst.prio_b", 64'(b_gnt), 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.a_rvalid", 64'(a_rvalid), 64'd0);
        chk("post_rst.b_rvalid", 64'(b_rvalid), 64'd0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 32'd0, 32'd0, "idle1");

        // Stall counter saturation with a 4-bit counter
        pulse_reset();
        drive(1'b1, 1'b1, 7'd40, 32'h0000_0001, 1'b1, 1'b1, 7'd41, 32'h0000_0002);
        for (int i = 0; i < 40; i++) begin
            chk("sat.stall", 64'(a_stall_cnt), 64'((i / 2) > 15 ? 15 : (i / 2)));
            step(i % 2 == 0, i % 2 == 1, 32'd0, 32'd0, "sat");
        end
        chk("sat.final", 64'(a_stall_cnt), 64'd15);
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, "idle2");
        step(1'b0, 1'b0, 32'd0, 32'd0, "idle3");

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
